// File: rtl/mux_arb_stage.sv
// N-input registered operand multiplexer with valid/ready handshakes.
// Channels are granted by a directed index or by a rotating round-robin search.
module mux_arb_stage #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic             load_ok;
  logic             found;
  logic             transfer;
  logic             dir_found;
  logic             rr_found;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_grant;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic [WIDTH-1:0] grant_data;

  // An out-of-range sel matches no channel, so it never finds a source.
  always_comb begin
    dir_found = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      dir_found = dir_found | ((sel == SEL_W'(i)) & in_valid[i]);
    end
  end

  // Search starts just past the last granted channel and wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = rr_ptr;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_idx = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end else begin
        rr_found = rr_found;
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant = rr_grant;
      found = rr_found;
    end else begin
      grant = sel;
      found = dir_found;
    end
  end

  assign load_ok  = !out_valid | out_ready;
  assign transfer = load_ok & found;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = transfer & (grant == SEL_W'(i));
      grant_data  = grant_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant == SEL_W'(i)}});
    end
  end

  // Output register: a new word may replace the held one in the same cycle it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_src   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SEL_W'(NUM_IN - 1);
    end else if (transfer && mode) begin
      rr_ptr <= grant;
    end
  end

endmodule
